// File: rtl/pt_stage_sequencer.sv
// pt_stage_sequencer: per-sample control sequencer strobing each Pan-Tompkins stage once per accepted sample
module pt_stage_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int NB_STAGES = 5,
   parameter int WARMUP = 32,
   localparam int CW = ($clog2(WARMUP + 1) > 1) ? $clog2(WARMUP + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic                 flush,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [NB_STAGES-1:0] stage_en,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 warm,
   output logic                 busy,
   output logic [CW-1:0]        sample_cnt
);
   typedef enum logic [1:0] {IDLE, STEP, OUT} state_t;
   localparam int IW = (NB_STAGES > 1) ? $clog2(NB_STAGES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NB_STAGES - 1);
   localparam logic [CW-1:0] WMAX = CW'(WARMUP);

   if (NB_STAGES < 1 || DATA_WIDTH < 1) begin : g_bad_params
      $error("pt_stage_sequencer: NB_STAGES and DATA_WIDTH must be at least 1");
   end

   state_t               state_q, state_d;
   logic [IW-1:0]        step_idx_q, step_idx_d;
   logic [CW-1:0]        sample_cnt_q, sample_cnt_d, cnt_inc;
   logic [NB_STAGES-1:0] stage_en_q, stage_en_d;
   logic                 cur_warm_q, cur_warm_d, warm_q, warm_d, m_valid_q, m_valid_d;
   logic                 accept;

   assign s_ready = rstn && en && !flush && state_q == IDLE;
   assign accept = s_valid && s_ready;
   assign cnt_inc = (sample_cnt_q == WMAX) ? sample_cnt_q : sample_cnt_q + CW'(1);
   // en gates the strobes so a frozen cycle never shifts a stage; the held register re-issues it on resume
   assign stage_en = en ? stage_en_q : '0;
   assign m_valid = en && m_valid_q;
   assign warm = warm_q;
   assign busy = state_q != IDLE;
   assign sample_cnt = sample_cnt_q;

   // next-state: flush wins, en low holds everything, otherwise walk IDLE -> STEP x NB_STAGES -> (OUT) -> IDLE
   always_comb begin
      state_d = state_q;
      step_idx_d = step_idx_q;
      sample_cnt_d = sample_cnt_q;
      cur_warm_d = cur_warm_q;
      stage_en_d = stage_en_q;
      m_valid_d = m_valid_q;
      warm_d = warm_q;
      if (en && flush) begin
         state_d = IDLE;
         step_idx_d = '0;
         sample_cnt_d = '0;
         cur_warm_d = 1'b0;
         stage_en_d = '0;
         m_valid_d = 1'b0;
         warm_d = 1'b0;
      end else if (en) begin
         case (state_q)
            IDLE: if (accept) begin
               state_d = STEP;
               step_idx_d = '0;
               sample_cnt_d = cnt_inc;
               cur_warm_d = cnt_inc == WMAX;
               stage_en_d = NB_STAGES'(1);
            end
            STEP: if (step_idx_q == LAST) begin
               state_d = cur_warm_q ? OUT : IDLE;
               step_idx_d = '0;
               stage_en_d = '0;
               m_valid_d = cur_warm_q;
            end else begin
               step_idx_d = step_idx_q + IW'(1);
               stage_en_d = NB_STAGES'(1) << (step_idx_q + IW'(1));
            end
            OUT: if (m_ready) begin
               state_d = IDLE;
               m_valid_d = 1'b0;
            end
            default: state_d = IDLE;
         endcase
         warm_d = sample_cnt_d == WMAX;
      end
   end

   // state and registered outputs, cleared asynchronously so a reset aborts any sequence at once
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         step_idx_q <= '0;
         sample_cnt_q <= '0;
         cur_warm_q <= 1'b0;
         stage_en_q <= '0;
         m_valid_q <= 1'b0;
         warm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_idx_q <= step_idx_d;
         sample_cnt_q <= sample_cnt_d;
         cur_warm_q <= cur_warm_d;
         stage_en_q <= stage_en_d;
         m_valid_q <= m_valid_d;
         warm_q <= warm_d;
      end
   end
endmodule
